// File: rtl/branch_predict_unit.sv
// RV32I conditional-branch resolver with a direct-mapped table of 2-bit saturating counters.
// Optional statistics counters are built only when BPU_STATS_EN is defined.
module branch_predict_unit #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] INIT_STATE  = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic [31:0]     res_pc,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [2:0]      br_sel,
    input  logic            res_pred,
    output logic            out_valid,
    output logic            br_taken,
    output logic            mispredict,
    output logic            br_illegal,
    input  logic            stats_clr,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Two-bit saturating step: up on taken, down on not-taken, pinned at 11 and 00.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            if (cnt == 2'b11) begin
                nxt = cnt;
            end else begin
                nxt = cnt + 2'b01;
            end
        end else begin
            if (cnt == 2'b00) begin
                nxt = cnt;
            end else begin
                nxt = cnt - 2'b01;
            end
        end
        return nxt;
    endfunction

    logic [1:0]       bht_r [BHT_ENTRIES];
    logic [IDX_W-1:0] pred_idx_s;
    logic [IDX_W-1:0] res_idx_s;
    logic             eq_s;
    logic             lt_s;
    logic             ltu_s;
    logic             cond_s;
    logic             legal_s;
    logic             upd_s;
    logic             out_valid_r;
    logic             br_taken_r;
    logic             mispredict_r;
    logic             br_illegal_r;

    assign pred_idx_s = pred_pc[IDX_W+1:2];
    assign res_idx_s  = res_pc[IDX_W+1:2];
    assign eq_s       = (in1 == in2);
    assign lt_s       = ($signed(in1) < $signed(in2));
    assign ltu_s      = (in1 < in2);
    assign upd_s      = res_valid & legal_s;

    // No bypass: a same-cycle update is seen by fetch only from the next cycle.
    assign pred_taken = bht_r[pred_idx_s][1];

    // Decode funct3 into the branch condition; 010/011 are not branches.
    always_comb begin
        cond_s  = 1'b0;
        legal_s = 1'b1;
        case (br_sel)
            F3_BEQ:  cond_s = eq_s;
            F3_BNE:  cond_s = ~eq_s;
            F3_BLT:  cond_s = lt_s;
            F3_BGE:  cond_s = ~lt_s;
            F3_BLTU: cond_s = ltu_s;
            F3_BGEU: cond_s = ~ltu_s;
            default: begin
                cond_s  = 1'b0;
                legal_s = 1'b0;
            end
        endcase
    end

    // Train the indexed counter with the actual outcome of each legal resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= INIT_STATE;
            end
        end else if (upd_s) begin
            bht_r[res_idx_s] <= sat_update(bht_r[res_idx_s], cond_s);
        end
    end

    // One-cycle result strobe with outcome, misprediction and illegal-code flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            br_taken_r   <= 1'b0;
            mispredict_r <= 1'b0;
            br_illegal_r <= 1'b0;
        end else if (res_valid) begin
            out_valid_r <= 1'b1;
            if (legal_s) begin
                br_taken_r   <= cond_s;
                mispredict_r <= cond_s ^ res_pred;
                br_illegal_r <= 1'b0;
            end else begin
                br_taken_r   <= 1'b0;
                mispredict_r <= 1'b0;
                br_illegal_r <= 1'b1;
            end
        end else begin
            out_valid_r  <= 1'b0;
            br_taken_r   <= 1'b0;
            mispredict_r <= 1'b0;
            br_illegal_r <= 1'b0;
        end
    end

    assign out_valid  = out_valid_r;
    assign br_taken   = br_taken_r;
    assign mispredict = mispredict_r;
    assign br_illegal = br_illegal_r;

`ifdef BPU_STATS_EN
    // Thirty-two bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] cnt);
        logic [31:0] nxt;
        if (cnt == 32'hFFFF_FFFF) begin
            nxt = cnt;
        end else begin
            nxt = cnt + 32'd1;
        end
        return nxt;
    endfunction

    logic [31:0] stat_branches_r;
    logic [31:0] stat_mispred_r;
    logic        unused_s;

    // Resolve statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_r <= 32'h0;
            stat_mispred_r  <= 32'h0;
        end else if (stats_clr) begin
            stat_branches_r <= 32'h0;
            stat_mispred_r  <= 32'h0;
        end else if (upd_s) begin
            stat_branches_r <= sat_inc32(stat_branches_r);
            if (cond_s ^ res_pred) begin
                stat_mispred_r <= sat_inc32(stat_mispred_r);
            end
        end
    end

    assign stat_branches = stat_branches_r;
    assign stat_mispred  = stat_mispred_r;
    assign unused_s      = ^{pred_pc, res_pc};
`else
    logic unused_s;

    assign stat_branches = 32'h0;
    assign stat_mispred  = 32'h0;
    assign unused_s      = ^{pred_pc, res_pc, stats_clr};
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: stimulus pushes expected results, a monitor pops them.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  br_sel;
    logic        res_pred;
    logic        out_valid;
    logic        br_taken;
    logic        mispredict;
    logic        br_illegal;
    logic        stats_clr;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    int          checks   = 0;
    int          failures = 0;
    logic [2:0]  exp_q[$];          // {br_taken, mispredict, br_illegal}
    logic [2:0]  mon_e;
    int unsigned exp_br = 0;
    int unsigned exp_mp = 0;

    branch_predict_unit dut (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_pc(res_pc), .in1(in1), .in2(in2),
        .br_sel(br_sel), .res_pred(res_pred), .out_valid(out_valid),
        .br_taken(br_taken), .mispredict(mispredict), .br_illegal(br_illegal),
        .stats_clr(stats_clr), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_res(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] sel, input logic pred, input logic taken);
        res_valid = 1'b1;
        res_pc    = pc;
        in1       = a;
        in2       = b;
        br_sel    = sel;
        res_pred  = pred;
        if (sel == 3'b010 || sel == 3'b011) begin
            exp_q.push_back(3'b001);
        end else begin
            exp_q.push_back({taken, taken ^ pred, 1'b0});
            exp_br++;
            if (taken ^ pred) exp_mp++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        res_valid = 1'b0;
        stats_clr = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] sel, input logic pred, input logic taken);
        drive_res(pc, a, b, sel, pred, taken);
        step();
    endtask

    task automatic chk_stats(input string name);
`ifdef BPU_STATS_EN
        chk({name, "_stat_branches"}, stat_branches, exp_br);
        chk({name, "_stat_mispred"}, stat_mispred, exp_mp);
`else
        chk({name, "_stat_branches"}, stat_branches, 32'h0);
        chk({name, "_stat_mispred"}, stat_mispred, 32'h0);
`endif
    endtask

    // Monitor: every result strobe must match the oldest expectation; idle cycles must be all-zero.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out_valid: got out_valid=1 expected no result");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("br_taken", {31'h0, br_taken}, {31'h0, mon_e[2]});
                    chk("mispredict", {31'h0, mispredict}, {31'h0, mon_e[1]});
                    chk("br_illegal", {31'h0, br_illegal}, {31'h0, mon_e[0]});
                end
            end else begin
                chk("idle_outputs", {29'h0, br_taken, mispredict, br_illegal}, 32'h0);
            end
        end
    end

    initial begin
        rst = 1'b1; pred_pc = 32'h0; res_valid = 1'b0; res_pc = 32'h0;
        in1 = 32'h0; in2 = 32'h0; br_sel = 3'b000; res_pred = 1'b0; stats_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        pred_pc = 32'h100;
        #1;
        chk("reset_pred_taken", {31'h0, pred_taken}, 32'h0);
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_flags", {29'h0, br_taken, mispredict, br_illegal}, 32'h0);
        chk_stats("reset");

        // BEQ taken with predicted not-taken: mispredict, counter 01 -> 10
        resolve(32'h100, 32'd5, 32'd5, 3'b000, 1'b0, 1'b1);
        idle();
        chk("beq_trains_pred", {31'h0, pred_taken}, 32'h1);

        // All six compares on -1 vs 1, back to back
        resolve(32'h004, 32'hFFFF_FFFF, 32'd1, 3'b000, 1'b0, 1'b0);
        resolve(32'h004, 32'hFFFF_FFFF, 32'd1, 3'b001, 1'b0, 1'b1);
        resolve(32'h004, 32'hFFFF_FFFF, 32'd1, 3'b100, 1'b0, 1'b1);
        resolve(32'h004, 32'hFFFF_FFFF, 32'd1, 3'b101, 1'b0, 1'b0);
        resolve(32'h004, 32'hFFFF_FFFF, 32'd1, 3'b110, 1'b0, 1'b0);
        resolve(32'h004, 32'hFFFF_FFFF, 32'd1, 3'b111, 1'b0, 1'b1);
        // Equal operands
        resolve(32'h00C, 32'd3, 32'd3, 3'b000, 1'b1, 1'b1);
        resolve(32'h00C, 32'd3, 32'd3, 3'b001, 1'b1, 1'b0);
        resolve(32'h00C, 32'd3, 32'd3, 3'b100, 1'b1, 1'b0);
        resolve(32'h00C, 32'd3, 32'd3, 3'b101, 1'b1, 1'b1);
        resolve(32'h00C, 32'd3, 32'd3, 3'b110, 1'b1, 1'b0);
        resolve(32'h00C, 32'd3, 32'd3, 3'b111, 1'b1, 1'b1);
        // Signed vs unsigned disagreement
        resolve(32'h00C, 32'd1, 32'hFFFF_FFFF, 3'b100, 1'b0, 1'b0);
        resolve(32'h00C, 32'd1, 32'hFFFF_FFFF, 3'b101, 1'b0, 1'b1);
        resolve(32'h00C, 32'd1, 32'hFFFF_FFFF, 3'b110, 1'b0, 1'b1);
        resolve(32'h00C, 32'd1, 32'hFFFF_FFFF, 3'b111, 1'b0, 1'b0);
        resolve(32'h00C, 32'h7FFF_FFFF, 32'h8000_0000, 3'b100, 1'b0, 1'b0);
        resolve(32'h00C, 32'h7FFF_FFFF, 32'h8000_0000, 3'b110, 1'b0, 1'b1);
        idle();

        // Upper saturation at 0x200 (shares entry 0 with 0x100, currently 10)
        pred_pc = 32'h200;
        repeat (4) resolve(32'h200, 32'd9, 32'd9, 3'b000, 1'b1, 1'b1);
        resolve(32'h200, 32'd9, 32'd9, 3'b001, 1'b1, 1'b0);
        idle();
        chk("sat_hi_one_down", {31'h0, pred_taken}, 32'h1);
        resolve(32'h200, 32'd9, 32'd9, 3'b001, 1'b1, 1'b0);
        idle();
        chk("sat_hi_two_down", {31'h0, pred_taken}, 32'h0);

        // Lower saturation at 0x008
        pred_pc = 32'h008;
        repeat (3) resolve(32'h008, 32'd1, 32'd2, 3'b000, 1'b0, 1'b0);
        resolve(32'h008, 32'd1, 32'd2, 3'b001, 1'b0, 1'b1);
        idle();
        chk("sat_lo_one_up", {31'h0, pred_taken}, 32'h0);
        resolve(32'h008, 32'd1, 32'd2, 3'b001, 1'b0, 1'b1);
        idle();
        chk("sat_lo_two_up", {31'h0, pred_taken}, 32'h1);

        // Illegal codes leave BHT (entry 0 = 01) and stats alone
        pred_pc = 32'h200;
        resolve(32'h200, 32'd7, 32'd7, 3'b010, 1'b1, 1'b0);
        resolve(32'h200, 32'd7, 32'd7, 3'b011, 1'b1, 1'b0);
        idle();
        chk("illegal_bht_hold", {31'h0, pred_taken}, 32'h0);
        chk_stats("illegal");

        // Aliasing 0x40 / 0x140 and same-cycle predict/update
        pred_pc = 32'h140;
        #1;
        chk("alias_before", {31'h0, pred_taken}, 32'h0);
        resolve(32'h040, 32'd0, 32'd0, 3'b000, 1'b0, 1'b1);
        resolve(32'h040, 32'd0, 32'd0, 3'b000, 1'b1, 1'b1);
        idle();
        chk("alias_after", {31'h0, pred_taken}, 32'h1);
        resolve(32'h040, 32'd0, 32'd1, 3'b000, 1'b1, 1'b0);
        pred_pc = 32'h040;
        drive_res(32'h040, 32'd0, 32'd1, 3'b000, 1'b1, 1'b0);
        #1;
        chk("same_cycle_old", {31'h0, pred_taken}, 32'h1);
        step();
        idle();
        chk("same_cycle_after", {31'h0, pred_taken}, 32'h0);

        // Statistics
        chk_stats("accum");
        drive_res(32'h300, 32'd1, 32'd2, 3'b000, 1'b1, 1'b0);
        stats_clr = 1'b1;
        exp_br = 0;
        exp_mp = 0;
        step();
        idle();
        chk_stats("clr_priority");
        for (int i = 0; i < 10; i++) begin
            logic tk;
            tk = (i != 0);
            resolve(32'h400 + 32'(4 * i), 32'(i), 32'd0, 3'b001, (i < 3) ? ~tk : tk, tk);
        end
        idle();
        chk_stats("ten_resolves");

        // Reset with a result in flight
        drive_res(32'h040, 32'd4, 32'd4, 3'b000, 1'b0, 1'b1);
        step();
        res_valid = 1'b0;
        chk("inflight_valid", {31'h0, out_valid}, 32'h1);
        rst = 1'b1;
        #1;
        chk("reset_drops_valid", {31'h0, out_valid}, 32'h0);
        exp_q.delete();
        exp_br = 0;
        exp_mp = 0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            pred_pc = 32'(i) << 2;
            #1;
            chk($sformatf("reset_bht_%0d", i), {31'h0, pred_taken}, 32'h0);
        end
        chk_stats("after_reset");
        pred_pc = 32'h040;
        resolve(32'h040, 32'd4, 32'd4, 3'b000, 1'b1, 1'b1);
        idle();
        chk("reset_state_weak", {31'h0, pred_taken}, 32'h1);

        step();
        step();
        chk("pending_results", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
